// File: rtl/fmap_stream_src_if.sv
// rtl/fmap_stream_src_if.sv - buffer write port, frame start/busy and output beat stream of fmap_stream_src
interface fmap_stream_src_if #(
  parameter int N          = 16,
  parameter int CHANNEL    = 3,
  parameter int INPUT_SIZE = 6
);
  localparam int DEPTH = INPUT_SIZE * INPUT_SIZE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [CHANNEL*N-1:0] wr_data;
  logic                 start;
  logic                 busy;
  logic [CHANNEL*N-1:0] dout;
  logic                 dout_vld;
  logic                 dout_end;

  modport master (
    input  wr_en, wr_addr, wr_data, start,
    output busy, dout, dout_vld, dout_end
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start,
    input  busy, dout, dout_vld, dout_end
  );
endinterface

// File: rtl/fmap_stream_src.sv
// rtl/fmap_stream_src.sv - feature-map stream transmitter: raster order, zero border, fixed inter-beat gap
// Optional FMAP_SRC_PINGPONG_EN: two buffer banks, writes accepted while a frame is in flight.
module fmap_stream_src #(
  parameter int N          = 16,
  parameter int CHANNEL    = 3,
  parameter int INPUT_SIZE = 6,
  parameter int PADDING    = 0,
  parameter int GAP        = 0
) (
  input  logic              clk,
  input  logic              rst,
  fmap_stream_src_if.master bus
);
  localparam int W     = CHANNEL * N;
  localparam int DEPTH = INPUT_SIZE * INPUT_SIZE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int P     = INPUT_SIZE + 2 * PADDING;
  localparam int CW    = (P > 1) ? $clog2(P) : 1;
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [GW-1:0] gap_cnt;
  logic          busy_q;
  logic          start_acc;
  logic          issue;
  logic          last_beat;
  logic          border;
  int            row_i;
  int            col_i;
  logic [AW-1:0] rd_addr;

  logic          s1_vld;
  logic          s1_border;
  logic          s1_end;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  dout_q;
  logic          dout_vld_q;
  logic          dout_end_q;

  logic          wr_ok;
  logic          rd_bank;
  logic          wr_bank;
  logic          wr_pend;
  logic          wr_pend_bank;
  logic [AW-1:0] wr_pend_addr;
  logic [W-1:0]  wr_pend_data;

`ifdef FMAP_SRC_PINGPONG_EN
  localparam int BANKS = 2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank <= 1'b0;
    end else if (start_acc) begin
      rd_bank <= ~rd_bank;
    end
  end

  assign wr_bank = ~rd_bank;
  assign wr_ok   = 1'b1;
`else
  localparam int BANKS = 1;

  assign rd_bank = 1'b0;
  assign wr_bank = 1'b0;
  assign wr_ok   = ~busy_q;
`endif

  logic [W-1:0] mem [BANKS][DEPTH];

  // Writes are staged one cycle so a start in the same cycle still reads the previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= bus.wr_en && wr_ok && (32'(bus.wr_addr) < DEPTH);
    end
    wr_pend_bank <= wr_bank;
    wr_pend_addr <= bus.wr_addr;
    wr_pend_data <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_pend) begin
      mem[wr_pend_bank][wr_pend_addr] <= wr_pend_data;
    end
    if (issue && !border) begin
      rd_data <= mem[rd_bank][rd_addr];
    end
  end

  always_comb begin
    row_i     = int'(row);
    col_i     = int'(col);
    border    = (row_i < PADDING) || (row_i >= PADDING + INPUT_SIZE) ||
                (col_i < PADDING) || (col_i >= PADDING + INPUT_SIZE);
    last_beat = (row_i == P - 1) && (col_i == P - 1);
    rd_addr   = AW'((row_i - PADDING) * INPUT_SIZE + (col_i - PADDING));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // busy stays high through DRAIN and the dout_end cycle, which also blocks a restart until then.
  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !busy_q) begin
          start_acc  = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        issue = 1'b1;
        if (last_beat) begin
          next_state = DRAIN;
        end else if (GAP > 0) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (int'(gap_cnt) == GAP - 1) begin
          next_state = SEND;
        end
      end
      DRAIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      row     <= '0;
      col     <= '0;
      gap_cnt <= '0;
    end else if (issue) begin
      gap_cnt <= '0;
      if (col_i == P - 1) begin
        col <= '0;
        row <= (row_i == P - 1) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else if (state == WAIT) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_border  <= 1'b0;
      s1_end     <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_end_q <= 1'b0;
    end else begin
      s1_vld     <= issue;
      s1_border  <= border;
      s1_end     <= last_beat;
      dout_vld_q <= s1_vld;
      dout_end_q <= s1_vld && s1_end;
      if (s1_vld) begin
        dout_q <= s1_border ? '0 : rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else if (start_acc) begin
      busy_q <= 1'b1;
    end else if (dout_end_q) begin
      busy_q <= 1'b0;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.dout_end = dout_end_q;
endmodule

// File: tb/tb_fmap_stream_src.sv
// tb/tb_fmap_stream_src.sv - scoreboard bench: unpadded back-to-back instance and padded gapped instance
// Expected beats are queued at frame start; per-instance monitors pop and compare on every dout_vld.
module tb_fmap_stream_src;
  localparam int N     = 16;
  localparam int CH    = 3;
  localparam int IS    = 6;
  localparam int W     = CH * N;
  localparam int DEPTH = IS * IS;
  localparam int AW    = $clog2(DEPTH);
  localparam int PB    = 1;
  localparam int GB    = 2;
  localparam int PSB   = IS + 2 * PB;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmap_stream_src_if #(.N(N), .CHANNEL(CH), .INPUT_SIZE(IS)) bus_a ();
  fmap_stream_src_if #(.N(N), .CHANNEL(CH), .INPUT_SIZE(IS)) bus_b ();

  fmap_stream_src #(.N(N), .CHANNEL(CH), .INPUT_SIZE(IS), .PADDING(0), .GAP(0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  fmap_stream_src #(.N(N), .CHANNEL(CH), .INPUT_SIZE(IS), .PADDING(PB), .GAP(GB)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  logic [W:0]   qa[$];
  logic [W:0]   qb[$];
  logic [W-1:0] pix_a [DEPTH];
  logic [W-1:0] pix_b [DEPTH];
  int beats_a = 0;
  int ends_a  = 0;
  int beats_b = 0;
  int ends_b  = 0;
  int fb_idx  = 0;
  int fb_first = 0;
  int fb_last  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic g_vld(input bit b);
    return b ? bus_b.dout_vld : bus_a.dout_vld;
  endfunction

  function automatic logic g_end(input bit b);
    return b ? bus_b.dout_end : bus_a.dout_end;
  endfunction

  function automatic logic g_busy(input bit b);
    return b ? bus_b.busy : bus_a.busy;
  endfunction

  initial forever begin
    logic [W:0] ea;
    @(negedge clk);
    if (!bus_a.dout_vld) begin
      chk("a_end_without_vld", 64'(bus_a.dout_end), 64'd0);
    end else begin
      beats_a++;
      if (bus_a.dout_end) ends_a++;
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_beat: got dout=%0h end=%0b, expected no beat", bus_a.dout, bus_a.dout_end);
      end else begin
        ea = qa.pop_front();
        chk("a_beat", 64'({bus_a.dout_end, bus_a.dout}), 64'(ea));
      end
    end
  end

  initial forever begin
    logic [W:0] eb;
    @(negedge clk);
    if (!bus_b.dout_vld) begin
      chk("b_end_without_vld", 64'(bus_b.dout_end), 64'd0);
    end else begin
      beats_b++;
      if (fb_idx > 0) chk("b_spacing", 64'(cyc - fb_last), 64'(GB + 1));
      else fb_first = cyc;
      fb_last = cyc;
      fb_idx++;
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_beat: got dout=%0h end=%0b, expected no beat", bus_b.dout, bus_b.dout_end);
      end else begin
        eb = qb.pop_front();
        chk("b_beat", 64'({bus_b.dout_end, bus_b.dout}), 64'(eb));
      end
      if (bus_b.dout_end) begin
        ends_b++;
        chk("b_span", 64'(cyc - fb_first), 64'((PSB * PSB - 1) * (GB + 1)));
        chk("b_frame_beats", 64'(fb_idx), 64'(PSB * PSB));
        fb_idx = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input bit b, input int addr, input logic [W-1:0] d);
    if (b) begin
      bus_b.wr_en = 1'b1; bus_b.wr_addr = AW'(addr); bus_b.wr_data = d;
    end else begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = AW'(addr); bus_a.wr_data = d;
    end
    tick();
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  task automatic push_frame_a();
    for (int i = 0; i < DEPTH; i++) qa.push_back({(i == DEPTH - 1), pix_a[i]});
  endtask

  task automatic push_frame_b();
    for (int r = 0; r < PSB; r++) begin
      for (int c = 0; c < PSB; c++) begin
        logic bd;
        bd = (r < PB) || (r >= PB + IS) || (c < PB) || (c >= PB + IS);
        qb.push_back({(r == PSB - 1 && c == PSB - 1), bd ? {W{1'b0}} : pix_b[(r - PB) * IS + (c - PB)]});
      end
    end
  endtask

  task automatic start_x(input bit b);
    if (b) bus_b.start = 1'b1;
    else bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic first_beat(input bit b, input string name);
    int j;
    j = 0;
    @(negedge clk);
    chk({name, "_busy_rise"}, 64'(g_busy(b)), 64'd1);
    while (!g_vld(b) && j < 10) begin
      @(negedge clk);
      j++;
    end
    chk({name, "_first_vld_latency"}, 64'(j), 64'd2);
  endtask

  task automatic wait_end(input bit b, input string name);
    int n;
    n = 0;
    while (!g_end(b) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_dout_end_seen"}, 64'(g_end(b)), 64'd1);
    chk({name, "_busy_at_end"}, 64'(g_busy(b)), 64'd1);
    @(negedge clk);
    chk({name, "_busy_fall"}, 64'(g_busy(b)), 64'd0);
  endtask

  task automatic settle(input string name);
    repeat (6) @(negedge clk);
    chk({name, "_queue_a_drained"}, 64'(qa.size()), 64'd0);
    chk({name, "_queue_b_drained"}, 64'(qb.size()), 64'd0);
  endtask

  task automatic wait_beats_a(input int from, input int count);
    int n;
    n = 0;
    while (beats_a - from < count && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    int b0;
    int e0;
    logic [W-1:0] new0;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.start = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.start = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset_a_busy", 64'(bus_a.busy), 64'd0);
    chk("reset_a_dout", 64'(bus_a.dout), 64'd0);
    chk("reset_a_vld", 64'(bus_a.dout_vld), 64'd0);
    chk("reset_a_end", 64'(bus_a.dout_end), 64'd0);
    chk("reset_b_busy", 64'(bus_b.busy), 64'd0);
    chk("reset_b_dout", 64'(bus_b.dout), 64'd0);
    chk("reset_b_vld", 64'(bus_b.dout_vld), 64'd0);
    chk("reset_b_end", 64'(bus_b.dout_end), 64'd0);

    for (int i = 0; i < DEPTH; i++) begin
      pix_a[i] = {3{16'(i)}};
      pix_b[i] = {3{16'(i)}};
      write_px(1'b0, i, pix_a[i]);
      write_px(1'b1, i, pix_b[i]);
    end

    // Unpadded, back-to-back: 36 beats carrying pixels 0..35.
    b0 = beats_a;
    push_frame_a();
    start_x(1'b0);
    first_beat(1'b0, "t1");
    wait_end(1'b0, "t1");
    chk("t1_beat_count", 64'(beats_a - b0), 64'(DEPTH));
    settle("t1");

    // Padded by 1 with GAP=2: 64 beats, zero ring, 3-cycle spacing.
    b0 = beats_b;
    push_frame_b();
    start_x(1'b1);
    first_beat(1'b1, "t2");
    wait_end(1'b1, "t2");
    chk("t2_beat_count", 64'(beats_b - b0), 64'(PSB * PSB));
    settle("t2");

    // Start while busy is ignored; a later start gives a complete second frame.
    e0 = ends_a;
    b0 = beats_a;
    push_frame_a();
    start_x(1'b0);
    wait_beats_a(b0, 10);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    wait_end(1'b0, "t4a");
    settle("t4a");
    chk("t4_single_end", 64'(ends_a - e0), 64'd1);
    chk("t4_single_frame_beats", 64'(beats_a - b0), 64'(DEPTH));
    push_frame_a();
    start_x(1'b0);
    first_beat(1'b0, "t4b");
    wait_end(1'b0, "t4b");
    settle("t4b");
    chk("t4_second_end", 64'(ends_a - e0), 64'd2);

    // Reset mid-frame aborts without dout_end; the stored map survives.
    e0 = ends_a;
    b0 = beats_a;
    push_frame_a();
    start_x(1'b0);
    wait_beats_a(b0, 20);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("t5_vld_after_rst", 64'(bus_a.dout_vld), 64'd0);
    chk("t5_busy_after_rst", 64'(bus_a.busy), 64'd0);
    chk("t5_end_after_rst", 64'(bus_a.dout_end), 64'd0);
    repeat (5) @(negedge clk);
    chk("t5_no_end_emitted", 64'(ends_a - e0), 64'd0);
    push_frame_a();
    start_x(1'b0);
    first_beat(1'b0, "t5");
    wait_end(1'b0, "t5");
    settle("t5");

    // Out-of-range write while idle is dropped; write while busy is dropped.
    write_px(1'b0, DEPTH + 5, {3{16'hDEAD}});
    push_frame_a();
    start_x(1'b0);
    write_px(1'b0, 5, {3{16'hABCD}});
    wait_end(1'b0, "t6a");
    settle("t6a");
    push_frame_a();
    start_x(1'b0);
    wait_end(1'b0, "t6b");
    settle("t6b");

    // Write in the same cycle as start: this frame reads the old pixel 0, the next one the new value.
    new0 = {3{16'h0F0F}};
    push_frame_a();
    bus_a.wr_en = 1'b1;
    bus_a.wr_addr = '0;
    bus_a.wr_data = new0;
    bus_a.start = 1'b1;
    tick();
    bus_a.wr_en = 1'b0;
    bus_a.start = 1'b0;
    pix_a[0] = new0;
    wait_end(1'b0, "t7a");
    settle("t7a");
    push_frame_a();
    start_x(1'b0);
    wait_end(1'b0, "t7b");
    settle("t7b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
